data_mem_unit: RTL and testbench

//  Parametrised successor to the single-cycle DataRAM: byte-addressed, little-endian data memory.

---
 rtl/data_mem_unit.sv | 200 ++++++++++++++++++++
 tb/tb_data_mem_unit.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_unit.sv
// Byte-addressed little-endian data memory with valid/ready request and
// response handshakes, configurable read latency and misalignment errors.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   req_valid/req_ready   request handshake (ready only while idle)
//   req_we                1 = store, 0 = load
//   req_size              00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned          loads: 1 = zero-extend, 0 = sign-extend
//   req_addr, req_wdata   byte address, right-aligned store data
//   rsp_valid/rsp_ready   response handshake; response held until taken
//   rsp_rdata, rsp_err    extended load data, error flag
module data_mem_unit #(
  parameter int ADDR_W    = 8,
  parameter int RD_LAT    = 1,
  parameter     INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int DEPTH = 1 << (ADDR_W - 2);
  localparam logic [1:0] LAT_M1 = 2'(RD_LAT - 1);

  typedef enum logic [1:0] {
    IDLE,
    RDWAIT,
    RESP
  } state_t;

  state_t state;
  state_t state_nx;

  logic [1:0]  cnt;
  logic [1:0]  cnt_nx;
  logic [31:0] data_q;
  logic [31:0] data_nx;
  logic        err_q;
  logic        err_nx;

  logic [31:0] mem [DEPTH];

  logic              accept;
  logic              bad;
  logic [ADDR_W-3:0] idx;
  logic [1:0]        lane;
  logic [3:0]        mask;
  logic [31:0]       wrep;
  logic              mem_we;
  logic [31:0]       rd_word;
  logic [31:0]       shifted;
  logic [31:0]       ld_data;

  assign accept = req_valid & req_ready;
  assign idx    = req_addr[ADDR_W-1:2];
  assign lane   = req_addr[1:0];

  always_comb begin
    bad = 1'b0;
    unique case (req_size)
      2'b00: bad = 1'b0;
      2'b01: bad = lane[0];
      2'b10: bad = (lane != 2'b00);
      default: bad = 1'b1;
    endcase
  end

  // Store data is replicated across lanes so the mask alone
  // picks which bytes land.
  always_comb begin
    mask = 4'b0000;
    wrep = req_wdata;
    unique case (req_size)
      2'b00: begin
        mask = 4'b0001 << lane;
        wrep = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        mask = lane[1] ? 4'b1100 : 4'b0011;
        wrep = {2{req_wdata[15:0]}};
      end
      2'b10: begin
        mask = 4'b1111;
        wrep = req_wdata;
      end
      default: begin
        mask = 4'b0000;
        wrep = req_wdata;
      end
    endcase
  end

  // A store racing reset is dropped, as is any erroring request.
  assign mem_we = rst_n & accept & req_we & ~bad;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (mask[i]) begin
          mem[idx][8*i +: 8] <= wrep[8*i +: 8];
        end
      end
    end
  end

  assign rd_word = mem[idx];
  assign shifted = rd_word >> {lane, 3'b000};

  always_comb begin
    ld_data = shifted;
    unique case (req_size)
      2'b00: begin
        if (req_unsigned) ld_data = {24'd0, shifted[7:0]};
        else ld_data = {{24{shifted[7]}}, shifted[7:0]};
      end
      2'b01: begin
        if (req_unsigned) ld_data = {16'd0, shifted[15:0]};
        else ld_data = {{16{shifted[15]}}, shifted[15:0]};
      end
      default: ld_data = shifted;
    endcase
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    data_nx  = data_q;
    err_nx   = err_q;
    unique case (state)
      IDLE: begin
        if (accept) begin
          err_nx  = bad;
          data_nx = (bad | req_we) ? 32'd0 : ld_data;
          if (bad | req_we) begin
            state_nx = RESP;
          end else if (RD_LAT <= 1) begin
            state_nx = RESP;
          end else begin
            state_nx = RDWAIT;
            cnt_nx   = LAT_M1;
          end
        end
      end
      RDWAIT: begin
        // Counter reaching zero on this edge means the response
        // becomes visible exactly RD_LAT cycles after accept.
        if (cnt <= 2'd1) begin
          state_nx = RESP;
          cnt_nx   = 2'd0;
        end else begin
          cnt_nx = cnt - 2'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_nx = IDLE;
          data_nx  = 32'd0;
          err_nx   = 1'b0;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = 2'd0;
        data_nx  = 32'd0;
        err_nx   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= 2'd0;
      data_q <= 32'd0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      data_q <= data_nx;
      err_q  <= err_nx;
    end
  end

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign rsp_rdata = rsp_valid ? data_q : 32'd0;
  assign rsp_err   = rsp_valid ? err_q : 1'b0;

endmodule

// File: tb/tb_data_mem_unit.sv
// Bench for data_mem_unit: byte-array reference model with a per-cycle
// compare, directed literal checks, and two extra instances for latency.
module tb_data_mem_unit;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  logic        x_rst_n;
  logic        x_req_valid;
  logic        x_req_we;
  logic [1:0]  x_req_size;
  logic        x_req_unsigned;
  logic [7:0]  x_req_addr;
  logic [31:0] x_req_wdata;
  logic        x_rsp_ready;
  logic        d1_req_ready, d4_req_ready;
  logic        d1_rsp_valid, d4_rsp_valid;
  logic [31:0] d1_rsp_rdata, d4_rsp_rdata;
  logic        d1_rsp_err, d4_rsp_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  data_mem_unit #(.ADDR_W(8), .RD_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  data_mem_unit #(.ADDR_W(8), .RD_LAT(1)) d1 (
    .clk(clk), .rst_n(x_rst_n),
    .req_valid(x_req_valid), .req_ready(d1_req_ready),
    .req_we(x_req_we), .req_size(x_req_size),
    .req_unsigned(x_req_unsigned), .req_addr(x_req_addr),
    .req_wdata(x_req_wdata),
    .rsp_valid(d1_rsp_valid), .rsp_ready(x_rsp_ready),
    .rsp_rdata(d1_rsp_rdata), .rsp_err(d1_rsp_err)
  );

  data_mem_unit #(.ADDR_W(8), .RD_LAT(4)) d4 (
    .clk(clk), .rst_n(x_rst_n),
    .req_valid(x_req_valid), .req_ready(d4_req_ready),
    .req_we(x_req_we), .req_size(x_req_size),
    .req_unsigned(x_req_unsigned), .req_addr(x_req_addr),
    .req_wdata(x_req_wdata),
    .rsp_valid(d4_rsp_valid), .rsp_ready(x_rsp_ready),
    .rsp_rdata(d4_rsp_rdata), .rsp_err(d4_rsp_err)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a flat byte array plus a "response due at cycle"
  logic [7:0]  mb [256];
  bit          live    = 0;
  bit          pending = 0;
  int          cyc     = 0;
  int          due     = 0;
  logic [31:0] exp_d;
  logic        exp_e;

  function automatic logic is_bad(input logic [1:0] sz, input logic [7:0] a);
    if (sz == 2'b11) return 1'b1;
    if (sz == 2'b01) return a % 2 != 0;
    if (sz == 2'b10) return a % 4 != 0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] sz,
      input logic u, input logic [7:0] a);
    int nb;
    logic [31:0] v;
    nb = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    v = 0;
    for (int b = 0; b < nb; b++) v = v | (32'(mb[8'(a + b)]) << (8 * b));
    if (!u && nb == 1 && v >= 32'h80) v = v - 32'h100;
    if (!u && nb == 2 && v >= 32'h8000) v = v - 32'h10000;
    return v;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      pending = 0;
      live    = 1;
    end else if (live) begin
      if (!pending) begin
        if (req_valid) begin
          exp_e = is_bad(req_size, req_addr);
          exp_d = 0;
          if (!exp_e && req_we) begin
            for (int b = 0; b < (1 << req_size); b++)
              mb[8'(req_addr + b)] = req_wdata[8*b +: 8];
          end else if (!exp_e) begin
            exp_d = model_load(req_size, req_unsigned, req_addr);
          end
          pending = 1;
          due = cyc + ((exp_e || req_we) ? 1 : LAT);
        end
      end else if (cyc >= due && rsp_ready) begin
        pending = 0;
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (live) begin
      bit ev;
      ev = pending && cyc >= due;
      chk("rsp_valid", 32'(rsp_valid), 32'(ev));
      chk("req_ready", 32'(req_ready), 32'(!pending));
      chk("rsp_rdata", rsp_rdata, ev ? exp_d : 32'd0);
      chk("rsp_err", 32'(rsp_err), ev ? 32'(exp_e) : 32'd0);
    end
  end

  task automatic txn(input logic we, input logic [1:0] sz, input logic u,
                     input logic [7:0] a, input logic [31:0] wd,
                     output logic [31:0] rd, output logic er);
    int n;
    @(negedge clk);
    req_valid = 1; req_we = we; req_size = sz; req_unsigned = u;
    req_addr = a; req_wdata = wd; rsp_ready = 1;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    chk("accept_in_time", 32'(n < 50), 32'd1);
    @(negedge clk);
    req_valid = 0;
    n = 0;
    while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
    chk("response_in_time", 32'(n < 50), 32'd1);
    rd = rsp_rdata;
    er = rsp_err;
    @(posedge clk);
  endtask

  initial begin
    logic [31:0] rd, hold;
    logic        er;

    rst_n = 0; req_valid = 0; req_we = 0; req_size = 0;
    req_unsigned = 0; req_addr = 0; req_wdata = 0; rsp_ready = 1;
    x_rst_n = 0; x_req_valid = 0; x_req_we = 0; x_req_size = 0;
    x_req_unsigned = 0; x_req_addr = 0; x_req_wdata = 0; x_rsp_ready = 1;
    repeat (3) @(negedge clk);
    rst_n = 1;

    for (int w = 0; w < 64; w++)
      txn(1, 2'b10, 0, 8'(w * 4), $urandom, rd, er);

    // Store held during reset must not be written
    txn(1, 2'b10, 0, 8'h20, 32'h11223344, rd, er);
    @(negedge clk);
    rst_n = 0; req_valid = 1; req_we = 1; req_size = 2'b10;
    req_addr = 8'h20; req_wdata = 32'hDEADBEEF;
    repeat (2) @(negedge clk);
    rst_n = 1; req_valid = 0;
    chk("ready_after_reset", 32'(req_ready), 32'd1);
    txn(0, 2'b10, 0, 8'h20, 0, rd, er);
    chk("reset_store_dropped", rd, 32'h11223344);

    txn(1, 2'b10, 0, 8'h10, 32'h8899AABB, rd, er);
    chk("sw_rdata_zero", rd, 32'd0);
    txn(0, 2'b00, 0, 8'h11, 0, rd, er);
    chk("lb_signed", rd, 32'hFFFFFFAA);
    txn(0, 2'b00, 1, 8'h13, 0, rd, er);
    chk("lbu", rd, 32'h00000088);
    txn(0, 2'b01, 0, 8'h12, 0, rd, er);
    chk("lh_signed", rd, 32'hFFFF8899);
    txn(1, 2'b00, 0, 8'h12, 32'h0000005A, rd, er);
    txn(0, 2'b10, 0, 8'h10, 0, rd, er);
    chk("sb_lane_merge", rd, 32'h885AAABB);

    txn(0, 2'b01, 0, 8'h11, 0, rd, er);
    chk("lh_mis_err", 32'(er), 32'd1);
    chk("lh_mis_rdata", rd, 32'd0);
    txn(0, 2'b11, 0, 8'h10, 0, rd, er);
    chk("size11_err", 32'(er), 32'd1);
    txn(0, 2'b10, 0, 8'h12, 0, rd, er);
    chk("lw_mis_err", 32'(er), 32'd1);
    txn(1, 2'b10, 0, 8'h12, 32'h0, rd, er);
    chk("sw_mis_err", 32'(er), 32'd1);

    // Latency and hold on the RD_LAT=3 instance
    @(negedge clk);
    req_valid = 1; req_we = 0; req_size = 2'b10; req_addr = 8'h10;
    rsp_ready = 0;
    chk("t5_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 0;
    for (int k = 1; k <= 3; k++) begin
      chk("t5_latency", 32'(rsp_valid), 32'(k == 3));
      if (k < 3) @(negedge clk);
    end
    hold = rsp_rdata;
    chk("t5_data", hold, 32'h885AAABB);
    repeat (4) begin
      @(negedge clk);
      chk("t5_hold_valid", 32'(rsp_valid), 32'd1);
      chk("t5_hold_data", rsp_rdata, hold);
      chk("t5_hold_busy", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1;
    @(negedge clk);
    chk("t5_idle_valid", 32'(rsp_valid), 32'd0);
    chk("t5_idle_ready", 32'(req_ready), 32'd1);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      int s;
      @(negedge clk);
      req_valid = ($urandom % 10) < 7;
      req_we = $urandom % 2;
      s = $urandom % 8;
      req_size = (s < 2) ? 2'b00 : (s < 4) ? 2'b01 : (s < 7) ? 2'b10 : 2'b11;
      req_unsigned = $urandom % 2;
      req_addr = 8'($urandom);
      if (($urandom % 10) < 7) req_addr[1:0] = 2'b00;
      req_wdata = $urandom;
      rsp_ready = ($urandom % 10) < 6;
    end
    @(negedge clk);
    req_valid = 0; rsp_ready = 1;
    repeat (8) @(negedge clk);

    // RD_LAT=1 and RD_LAT=4 instances
    x_rst_n = 0;
    repeat (2) @(negedge clk);
    x_rst_n = 1;
    @(negedge clk);
    chk("d1_ready", 32'(d1_req_ready), 32'd1);
    chk("d4_ready", 32'(d4_req_ready), 32'd1);
    x_req_valid = 1; x_req_we = 1; x_req_size = 2'b10;
    x_req_addr = 8'h40; x_req_wdata = 32'hCAFEF00D;
    @(negedge clk);
    x_req_valid = 0;
    chk("d4_store_rsp", 32'(d4_rsp_valid), 32'd1);
    chk("d1_store_rsp", 32'(d1_rsp_valid), 32'd1);
    @(negedge clk);
    x_rsp_ready = 0; x_req_valid = 1; x_req_we = 0;
    @(negedge clk);
    x_req_valid = 0;
    for (int k = 1; k <= 5; k++) begin
      chk("d1_lat", 32'(d1_rsp_valid), 32'd1);
      chk("d4_lat", 32'(d4_rsp_valid), 32'(k >= 4));
      if (k == 1) chk("d1_data", d1_rsp_rdata, 32'hCAFEF00D);
      if (k == 4) chk("d4_data", d4_rsp_rdata, 32'hCAFEF00D);
      if (k < 5) @(negedge clk);
    end
    x_rsp_ready = 1;
    @(negedge clk);
    chk("d4_consumed", 32'(d4_req_ready), 32'd1);
    chk("d1_consumed", 32'(d1_req_ready), 32'd1);

    // Reset two cycles into a RD_LAT=4 read aborts it
    x_rsp_ready = 0; x_req_valid = 1;
    @(negedge clk);
    x_req_valid = 0;
    chk("d4_abort_k1", 32'(d4_rsp_valid), 32'd0);
    @(negedge clk);
    x_rst_n = 0;
    @(negedge clk);
    x_rst_n = 1;
    repeat (8) begin
      @(negedge clk);
      chk("d4_abort_valid", 32'(d4_rsp_valid), 32'd0);
      chk("d4_abort_ready", 32'(d4_req_ready), 32'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
